// File: rtl/lcd_cmd_queue.sv
// Command-issue queue in front of the LCD display controller: buffers host opcodes
// and paces issue on busy/done. Define LCD_CMDQ_FILTER_EN to drop opcodes 4'hC-4'hF.
`timescale 1ns/1ps
module lcd_cmd_queue #(
    parameter int DEPTH       = 8,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [3:0]               host_cmd,
    input  logic                     host_valid,
    output logic                     host_ready,
    output logic [3:0]               cmd,
    output logic                     cmd_valid,
    input  logic                     busy,
    input  logic                     done,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     halted,
    output logic                     ack_err,
    output logic [7:0]               drop_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = DEPTH[AW:0];
    localparam logic [7:0]  TMO  = ACK_TIMEOUT[7:0];

    typedef enum logic [2:0] {
        IDLE, ISSUE, WAIT_ACK, WAIT_FREE, WAIT_DONE, HALT
    } state_t;

    state_t         state;
    logic [3:0]     mem [DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [7:0]     ack_cnt;
    logic           last_wr;
    logic           drop, push, pop;

    assign host_ready = (level != FULL);
    assign halted     = (state == HALT);

`ifdef LCD_CMDQ_FILTER_EN
    // Filtered opcodes still complete the host handshake but never reach the buffer.
    assign drop = host_valid && host_ready && (host_cmd[3:2] == 2'b11);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            drop_cnt <= 8'd0;
        else if (drop && drop_cnt != 8'hFF)
            drop_cnt <= drop_cnt + 8'd1;
    end
`else
    assign drop     = 1'b0;
    assign drop_cnt = 8'd0;
`endif

    assign push = host_valid && host_ready && !drop;
    assign pop  = (state == IDLE) && !done && (level != '0) && !busy;

    // Contents need no reset: occupancy alone defines what is valid.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= host_cmd;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                level <= level + 1'b1;
            else if (pop && !push)
                level <= level - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cmd       <= 4'd0;
            cmd_valid <= 1'b0;
            ack_cnt   <= 8'd0;
            last_wr   <= 1'b0;
            ack_err   <= 1'b0;
        end else if (done && state != HALT) begin
            // done wins from any state; a pending strobe still drops after one cycle
            state     <= HALT;
            cmd_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        cmd       <= mem[rd_ptr];
                        cmd_valid <= 1'b1;
                        last_wr   <= (mem[rd_ptr] == 4'b0000);
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    cmd_valid <= 1'b0;
                    ack_cnt   <= 8'd0;
                    state     <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (busy) begin
                        state <= WAIT_FREE;
                    end else if (ack_cnt + 8'd1 == TMO) begin
                        // give up on this opcode; it is not re-issued
                        ack_err <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        ack_cnt <= ack_cnt + 8'd1;
                    end
                end
                WAIT_FREE: begin
                    if (!busy)
                        state <= last_wr ? WAIT_DONE : IDLE;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_lcd_cmd_queue.sv
// Directed bench for lcd_cmd_queue: reset, issue pacing, fill/order, write-halt,
// ack timeout, optional filter and async reset mid-operation.
`timescale 1ns/1ps
module tb_lcd_cmd_queue;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] host_cmd = 4'd0;
    logic       host_valid = 1'b0;
    logic       host_ready;
    logic [3:0] cmd;
    logic       cmd_valid;
    logic       busy;
    logic       busy_drv = 1'b1;
    logic       done = 1'b0;
    logic [3:0] level;
    logic       halted;
    logic       ack_err;
    logic [7:0] drop_cnt;
    logic       model_en = 1'b0;
    int         mcnt = 0;
    int         errors = 0;
    int         checks = 0;

    lcd_cmd_queue #(.DEPTH(8), .ACK_TIMEOUT(15)) dut (
        .clk(clk), .reset(reset), .host_cmd(host_cmd), .host_valid(host_valid),
        .host_ready(host_ready), .cmd(cmd), .cmd_valid(cmd_valid), .busy(busy),
        .done(done), .level(level), .halted(halted), .ack_err(ack_err),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    // controller model: busy for 2 cycles after each issue strobe
    assign busy = model_en ? (mcnt != 0) : busy_drv;
    always @(posedge clk) begin
        if (!model_en)      mcnt <= 0;
        else if (cmd_valid) mcnt <= 2;
        else if (mcnt != 0) mcnt <= mcnt - 1;
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic push(input logic [3:0] c);
        host_cmd = c; host_valid = 1'b1;
        tick();
        host_valid = 1'b0;
    endtask

    task automatic apply_reset();
        model_en = 1'b0; done = 1'b0; host_valid = 1'b0; busy_drv = 1'b1;
        reset = 1'b0;
        tick(); tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0; busy_drv = 1'b1;
        tick(); tick();
        checks++; if (level !== 4'd0)     begin errors++; $display("FAIL rst_level got %0d want 0", level); end
        checks++; if (host_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", host_ready); end
        checks++; if (cmd !== 4'd0)       begin errors++; $display("FAIL rst_cmd got %h want 0", cmd); end
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL rst_cvalid got %b want 0", cmd_valid); end
        checks++; if (halted !== 1'b0)    begin errors++; $display("FAIL rst_halted got %b want 0", halted); end
        checks++; if (ack_err !== 1'b0)   begin errors++; $display("FAIL rst_ackerr got %b want 0", ack_err); end
        checks++; if (drop_cnt !== 8'd0)  begin errors++; $display("FAIL rst_drop got %0d want 0", drop_cnt); end
        reset = 1'b1;
    endtask

    task automatic test_reset_issue();
        int bad;
        bad = 0;
        push(4'h1);
        checks++; if (level !== 4'd1) begin errors++; $display("FAIL ri_level got %0d want 1", level); end
        repeat (10) begin
            tick();
            if (cmd_valid !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL ri_busy_hold got %0d strobes want 0", bad); end
        busy_drv = 1'b0;
        tick();
        checks++; if (cmd_valid !== 1'b1) begin errors++; $display("FAIL ri_cvalid got %b want 1", cmd_valid); end
        checks++; if (cmd !== 4'h1)       begin errors++; $display("FAIL ri_cmd got %h want 1", cmd); end
        checks++; if (level !== 4'd0)     begin errors++; $display("FAIL ri_level0 got %0d want 0", level); end
        tick();
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL ri_strobe_len got %b want 0", cmd_valid); end
    endtask

    task automatic test_latency();
        apply_reset();
        busy_drv = 1'b0;
        push(4'h6);
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL lat_nobypass got %b want 0", cmd_valid); end
        tick();
        checks++; if (cmd_valid !== 1'b1 || cmd !== 4'h6) begin errors++; $display("FAIL lat_issue got %b/%h want 1/6", cmd_valid, cmd); end
        tick();
        checks++; if (cmd_valid !== 1'b0 || cmd !== 4'h6) begin errors++; $display("FAIL lat_hold got %b/%h want 0/6", cmd_valid, cmd); end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        busy_drv = 1'b0;
        push(4'h1);
        push(4'h2);
        checks++; if (level !== 4'd1) begin errors++; $display("FAIL b2b_level got %0d want 1", level); end
        checks++; if (cmd_valid !== 1'b1 || cmd !== 4'h1) begin errors++; $display("FAIL b2b_issue got %b/%h want 1/1", cmd_valid, cmd); end
    endtask

    task automatic test_fill();
        logic [3:0] got [8];
        int n, overlap, wrong;
        apply_reset();
        for (int i = 1; i <= 8; i++) push(4'(i));
        checks++; if (level !== 4'd8 || host_ready !== 1'b0) begin errors++; $display("FAIL fill_full got %0d/%b want 8/0", level, host_ready); end
        push(4'h9);
        checks++; if (level !== 4'd8) begin errors++; $display("FAIL fill_refuse got %0d want 8", level); end
        // push attempted in the same cycle as the first pop while full
        host_cmd = 4'hA; host_valid = 1'b1; busy_drv = 1'b0; model_en = 1'b1;
        tick();
        host_valid = 1'b0;
        checks++; if (level !== 4'd7) begin errors++; $display("FAIL fill_popfull got %0d want 7", level); end
        checks++; if (cmd_valid !== 1'b1 || cmd !== 4'h1) begin errors++; $display("FAIL fill_first got %b/%h want 1/1", cmd_valid, cmd); end
        got[0] = cmd; n = 1; overlap = 0;
        for (int c = 0; c < 200 && n < 8; c++) begin
            tick();
            if (cmd_valid === 1'b1 && busy === 1'b1) overlap++;
            if (cmd_valid === 1'b1) begin got[n] = cmd; n++; end
        end
        checks++; if (n != 8) begin errors++; $display("FAIL fill_count got %0d want 8", n); end
        checks++; if (overlap != 0) begin errors++; $display("FAIL fill_overlap got %0d want 0", overlap); end
        wrong = 0;
        for (int i = 0; i < n; i++) if (got[i] !== 4'(i + 1)) wrong++;
        checks++; if (wrong != 0) begin errors++; $display("FAIL fill_order got %0d misordered want 0", wrong); end
        checks++; if (level !== 4'd0) begin errors++; $display("FAIL fill_drain got %0d want 0", level); end
    endtask

    task automatic test_write_halt();
        logic [3:0] got [4];
        int n, cd, extra;
        logic wr_seen, bhi;
        apply_reset();
        push(4'h5); push(4'h0); push(4'h3);
        model_en = 1'b1;
        n = 0; cd = -1; wr_seen = 0; bhi = 0;
        for (int c = 0; c < 300 && halted !== 1'b1; c++) begin
            tick();
            if (cmd_valid === 1'b1) begin
                if (n < 4) got[n] = cmd;
                n++;
                if (cmd === 4'h0) wr_seen = 1;
            end
            if (cd > 0) begin
                cd--;
                if (cd == 0) done = 1'b1;
            end
            if (wr_seen && busy === 1'b1) bhi = 1;
            else if (bhi && busy === 1'b0 && cd < 0) cd = 4;
        end
        extra = 0;
        repeat (20) begin
            tick();
            if (cmd_valid === 1'b1) extra++;
        end
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL wh_halted got %b want 1", halted); end
        checks++; if (n != 2) begin errors++; $display("FAIL wh_count got %0d want 2", n); end
        checks++; if (n >= 2 && (got[0] !== 4'h5 || got[1] !== 4'h0)) begin errors++; $display("FAIL wh_order got %h,%h want 5,0", got[0], got[1]); end
        checks++; if (extra != 0) begin errors++; $display("FAIL wh_noissue got %0d want 0", extra); end
        checks++; if (level !== 4'd1) begin errors++; $display("FAIL wh_level got %0d want 1", level); end
        push(4'h7);
        checks++; if (level !== 4'd2 || host_ready !== 1'b1) begin errors++; $display("FAIL wh_push got %0d/%b want 2/1", level, host_ready); end
        done = 1'b0;
    endtask

    task automatic test_ack_timeout();
        apply_reset();
        push(4'hA); push(4'hB);
        busy_drv = 1'b0;
        tick();
        checks++; if (cmd_valid !== 1'b1 || cmd !== 4'hA) begin errors++; $display("FAIL to_issue got %b/%h want 1/a", cmd_valid, cmd); end
        for (int k = 1; k <= 17; k++) begin
            tick();
            if (k == 5) begin
                checks++; if (cmd !== 4'hA) begin errors++; $display("FAIL to_hold got %h want a", cmd); end
            end
            if (k == 15) begin
                checks++; if (ack_err !== 1'b0) begin errors++; $display("FAIL to_early got %b want 0", ack_err); end
            end
            if (k == 16) begin
                checks++; if (ack_err !== 1'b1 || cmd_valid !== 1'b0) begin errors++; $display("FAIL to_err got %b/%b want 1/0", ack_err, cmd_valid); end
            end
            if (k == 17) begin
                checks++; if (cmd_valid !== 1'b1 || cmd !== 4'hB) begin errors++; $display("FAIL to_next got %b/%h want 1/b", cmd_valid, cmd); end
            end
        end
    endtask

    task automatic test_filter();
        logic [3:0] exp_q [3];
        logic [3:0] got [4];
        int exp_n, n, wrong;
        apply_reset();
        push(4'hC); push(4'h2); push(4'hF);
`ifdef LCD_CMDQ_FILTER_EN
        exp_n = 1; exp_q[0] = 4'h2; exp_q[1] = 4'h0; exp_q[2] = 4'h0;
        checks++; if (level !== 4'd1 || drop_cnt !== 8'd2) begin errors++; $display("FAIL flt_enq got %0d/%0d want 1/2", level, drop_cnt); end
`else
        exp_n = 3; exp_q[0] = 4'hC; exp_q[1] = 4'h2; exp_q[2] = 4'hF;
        checks++; if (level !== 4'd3 || drop_cnt !== 8'd0) begin errors++; $display("FAIL flt_enq got %0d/%0d want 3/0", level, drop_cnt); end
`endif
        model_en = 1'b1;
        n = 0;
        for (int c = 0; c < 100; c++) begin
            tick();
            if (cmd_valid === 1'b1) begin
                if (n < 4) got[n] = cmd;
                n++;
            end
        end
        checks++; if (n != exp_n) begin errors++; $display("FAIL flt_count got %0d want %0d", n, exp_n); end
        wrong = 0;
        for (int i = 0; i < exp_n && i < n; i++) if (got[i] !== exp_q[i]) wrong++;
        checks++; if (wrong != 0) begin errors++; $display("FAIL flt_order got %0d wrong want 0", wrong); end
    endtask

    task automatic test_async_reset();
        apply_reset();
        push(4'h1); push(4'h2); push(4'h3); push(4'h4);
        busy_drv = 1'b0;
        tick();
        busy_drv = 1'b1;
        tick(); tick();
        checks++; if (level !== 4'd3 || cmd !== 4'h1) begin errors++; $display("FAIL ar_pre got %0d/%h want 3/1", level, cmd); end
        #3 reset = 1'b0;
        #1;
        checks++; if (level !== 4'd0 || host_ready !== 1'b1) begin errors++; $display("FAIL ar_fifo got %0d/%b want 0/1", level, host_ready); end
        checks++; if (cmd !== 4'd0 || cmd_valid !== 1'b0) begin errors++; $display("FAIL ar_cmd got %h/%b want 0/0", cmd, cmd_valid); end
        checks++; if (halted !== 1'b0 || ack_err !== 1'b0) begin errors++; $display("FAIL ar_flags got %b/%b want 0/0", halted, ack_err); end
        tick();
        reset = 1'b1;
    endtask

    initial begin
        test_reset();
        test_reset_issue();
        test_latency();
        test_back_to_back();
        test_fill();
        test_write_halt();
        test_ack_timeout();
        test_filter();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end
endmodule
